// File: rtl/kronos_fpga_pkg.sv
// kronos_fpga_pkg: shared sequencer state encoding and default timing constants
package kronos_fpga_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_STRAP, ST_RUN} seq_state_e;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 64;
  localparam int unsigned CNT_W = 16;
endpackage

// File: rtl/fpga_reset_sequencer_if.sv
// fpga_reset_sequencer_if: SoC exit report bundle (SoC drives, sequencer samples)
interface fpga_reset_sequencer_if;
  logic        exit_valid;
  logic [31:0] exit_value;
  modport master (output exit_valid, output exit_value);
  modport slave (input exit_valid, input exit_value);
endinterface

// File: rtl/fpga_debouncer.sv
// fpga_debouncer: 2-flop synchronizer plus consecutive-cycle debounce counter
module fpga_debouncer
  import kronos_fpga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic db_o
);
  logic [1:0]       sync_q, sync_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // accept the synchronized value once it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
  end
  // state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end
  assign db_o = db_q;
endmodule

// File: rtl/fpga_reset_sequencer.sv
// fpga_reset_sequencer: board-level reset release sequencing, strap latching and exit capture
module fpga_reset_sequencer
  import kronos_fpga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES          = DEFAULT_HOLD_CYCLES,
  parameter int unsigned CLK_LED_COUNT_LENGTH = 27
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pll_locked_i,
  input  logic        btn_rst_i,
  input  logic        boot_select_i,
  input  logic        execute_from_flash_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        exit_valid_o,
  output logic        exit_value_o,
  output logic        rst_led_o,
  output logic        clk_led_o
);
  seq_state_e                state_q, state_d;
  logic [CNT_W-1:0]          hold_cnt_q, hold_cnt_d;
  logic [2:0]                sync1_q, sync1_d, sync2_q, sync2_d;
  logic                      rst_n_q, rst_n_d;
  logic                      boot_q, boot_d, xip_q, xip_d;
  logic                      exit_v_q, exit_v_d, exit_val_q, exit_val_d;
  logic [CLK_LED_COUNT_LENGTH-1:0] hb_q, hb_d;
  logic                      btn_db, lock_s, force_assert, unused_exit;
  fpga_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .raw_i (btn_rst_i),
    .db_o  (btn_db)
  );
  assign lock_s       = sync2_q[0];
  assign force_assert = !lock_s || btn_db;
  assign unused_exit  = ^exit_value_i[31:1];
  // synchronizers for lock and straps, plus the free-running heartbeat
  always_comb begin
    sync1_d = {execute_from_flash_i, boot_select_i, pll_locked_i};
    sync2_d = sync1_q;
    hb_d    = hb_q + 1'b1;
  end
  // sequencer next state; loss of lock or a debounced press overrides everything
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rst_n_d    = rst_n_q;
    boot_d     = boot_q;
    xip_d      = xip_q;
    exit_v_d   = exit_v_q;
    exit_val_d = exit_val_q;
    if (force_assert) begin
      state_d    = ST_ASSERT;
      hold_cnt_d = '0;
      rst_n_d    = 1'b0;
      exit_v_d   = 1'b0;
      exit_val_d = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
        ST_HOLD: begin
          state_d    = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) ? ST_STRAP : ST_HOLD;
          hold_cnt_d = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) ? '0 : hold_cnt_q + 1'b1;
        end
        ST_STRAP: begin
          state_d = ST_RUN;
          boot_d  = sync2_q[1];
          xip_d   = sync2_q[2];
          rst_n_d = 1'b1;
        end
        ST_RUN: begin
          if (exit_valid_i && !exit_v_q) begin
            exit_v_d   = 1'b1;
            exit_val_d = exit_value_i[0];
          end
        end
        default: state_d = ST_ASSERT;
      endcase
    end
  end
  // state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ASSERT;
      hold_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      rst_n_q    <= 1'b0;
      boot_q     <= 1'b0;
      xip_q      <= 1'b0;
      exit_v_q   <= 1'b0;
      exit_val_q <= 1'b0;
      hb_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rst_n_q    <= rst_n_d;
      boot_q     <= boot_d;
      xip_q      <= xip_d;
      exit_v_q   <= exit_v_d;
      exit_val_q <= exit_val_d;
      hb_q       <= hb_d;
    end
  end
  assign rst_no               = rst_n_q;
  assign rst_led_o            = rst_n_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = xip_q;
  assign exit_valid_o         = exit_v_q;
  assign exit_value_o         = exit_val_q;
  assign clk_led_o            = hb_q[CLK_LED_COUNT_LENGTH-1];
endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// tb_fpga_reset_sequencer: directed and randomized checks against a behavioural sequencer model
module tb_fpga_reset_sequencer;
  localparam int DB = 4;
  localparam int HC = 8;
  localparam int LW = 4;
  logic clk = 1'b0, rst = 1'b0, lock = 1'b0, btn = 1'b0, boot = 1'b0, xip = 1'b0;
  logic rst_no, boot_o, xip_o, exv_o, exval_o, rst_led, clk_led;
  int n_chk = 0, n_pass = 0;
  fpga_reset_sequencer_if ex_if ();
  fpga_reset_sequencer #(.DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .CLK_LED_COUNT_LENGTH(LW)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .pll_locked_i         (lock),
    .btn_rst_i            (btn),
    .boot_select_i        (boot),
    .execute_from_flash_i (xip),
    .exit_valid_i         (ex_if.exit_valid),
    .exit_value_i         (ex_if.exit_value),
    .rst_no               (rst_no),
    .boot_select_o        (boot_o),
    .execute_from_flash_o (xip_o),
    .exit_valid_o         (exv_o),
    .exit_value_o         (exval_o),
    .rst_led_o            (rst_led),
    .clk_led_o            (clk_led)
  );
  always #5 clk = ~clk;
  logic [1:0] m_lk, m_bt, m_bs, m_xf;
  logic m_db, m_frc, m_rstn, m_boot, m_xip, m_ev, m_eval;
  logic [LW-1:0] m_hb;
  int m_run, m_seq;
  // model: m_seq is -1 while reset is forced, 0..HC-1 while holding, HC for the strap cycle, HC+1 running
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lk = 0; m_bt = 0; m_bs = 0; m_xf = 0;
      m_db = 0; m_run = 0; m_seq = -1; m_rstn = 0;
      m_boot = 0; m_xip = 0; m_ev = 0; m_eval = 0; m_hb = 0;
    end else begin
      m_frc = !m_lk[1] || m_db;
      if (m_frc) begin
        m_seq = -1; m_rstn = 0; m_ev = 0; m_eval = 0;
      end else if (m_seq < HC) m_seq++;
      else if (m_seq == HC) begin
        m_boot = m_bs[1]; m_xip = m_xf[1]; m_rstn = 1; m_seq = HC + 1;
      end else if (ex_if.exit_valid && !m_ev) begin
        m_ev = 1; m_eval = ex_if.exit_value[0];
      end
      if (m_bt[1] != m_db) begin
        m_run++;
        if (m_run == DB) begin m_db = m_bt[1]; m_run = 0; end
      end else m_run = 0;
      m_lk = {m_lk[0], lock}; m_bt = {m_bt[0], btn};
      m_bs = {m_bs[0], boot}; m_xf = {m_xf[0], xip};
      m_hb = m_hb + 1'b1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic check_all();
    check("rst_no", rst_no, m_rstn);
    check("rst_led", rst_led, m_rstn);
    check("boot_select", boot_o, m_boot);
    check("exec_flash", xip_o, m_xip);
    check("exit_valid", exv_o, m_ev);
    check("exit_value", exval_o, m_eval);
    check("clk_led", clk_led, m_hb[LW-1]);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask
  task automatic wait_rst_no(input logic lvl, input string tag, input int exp);
    int lat = 0;
    while (rst_no !== lvl && lat < 60) begin step(1); lat++; end
    check(tag, lat, exp);
  endtask
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1 check_all();
    check("async_rst_no", rst_no, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask
  initial begin
    int btn_left;
    ex_if.exit_valid = 1'b0;
    ex_if.exit_value = '0;
    #1 rst = 1'b1;
    #2 check_all();
    check("reset_rst_no", rst_no, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(9);
    lock = 1'b1; boot = 1'b1;
    wait_rst_no(1'b1, "lock_latency", 12);
    step(2); boot = 1'b0; step(3); boot = 1'b1; step(2); boot = 1'b0; step(4);
    check("boot_held", boot_o, 1'b1);
    btn = 1'b1; step(1); btn = 1'b0; step(1); btn = 1'b1; step(1); btn = 1'b0; step(8);
    check("bounce_ignored", rst_no, 1'b1);
    ex_if.exit_valid = 1'b1; ex_if.exit_value = 32'h1; step(1);
    ex_if.exit_valid = 1'b0; step(2);
    ex_if.exit_valid = 1'b1; ex_if.exit_value = 32'h0; step(1);
    ex_if.exit_valid = 1'b0; step(1);
    check("exit_valid_sticky", exv_o, 1'b1);
    check("exit_value_kept", exval_o, 1'b1);
    btn = 1'b1;
    wait_rst_no(1'b0, "press_latency", 7);
    check("exit_cleared", exv_o, 1'b0);
    btn = 1'b0;
    wait_rst_no(1'b1, "release_latency", 16);
    lock = 1'b0; step(4);
    lock = 1'b1; step(6);
    lock = 1'b0; step(3);
    check("lock_drop_hold", rst_no, 1'b0);
    lock = 1'b1;
    wait_rst_no(1'b1, "relock_latency", 12);
    step(3);
    pulse_rst();
    wait_rst_no(1'b1, "restart_latency", 12);
    btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (lock) lock = ($urandom_range(0, 149) != 0);
      else lock = ($urandom_range(0, 3) == 0);
      if (btn_left > 0) begin btn = 1'($urandom); btn_left--; end
      else if ($urandom_range(0, 199) == 0) btn_left = $urandom_range(1, 12);
      else btn = 1'b0;
      if ($urandom_range(0, 7) == 0) boot = ~boot;
      if ($urandom_range(0, 7) == 0) xip = ~xip;
      ex_if.exit_valid = ($urandom_range(0, 19) == 0);
      ex_if.exit_value = $urandom;
      if ($urandom_range(0, 499) == 0) pulse_rst();
      else step(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpga_reset_sequencer.md
FPGA_RESET_SEQUENCER -- requirements
Module: fpga_reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable cycles needed to accept a button change (range 2..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 64, the number of cycles reset is held after lock is stable and the button is released (range 2..65535).
REQ-003 SHALL have parameter CLK_LED_COUNT_LENGTH, default 27, the width of the heartbeat counter.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock, the clock-wizard output.
REQ-005 SHALL have port rst_i, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 SHALL have port pll_locked_i, input, 1 bit: asynchronous clock-wizard lock indication.
REQ-007 SHALL have port btn_rst_i, input, 1 bit: raw, bouncing reset push-button, active-high.
REQ-008 SHALL have ports boot_select_i and execute_from_flash_i, input, 1 bit each: raw strap pins.
REQ-009 SHALL have port exit_valid_i, input, 1 bit, and port exit_value_i, input, 32 bits: the SoC exit report.
REQ-010 SHALL have port rst_no, output, 1 bit: active-low reset to kronos_x_heep_top.
REQ-011 SHALL have ports boot_select_o and execute_from_flash_o, output, 1 bit each: latched straps.
REQ-012 SHALL have ports exit_valid_o and exit_value_o, output, 1 bit each: sticky exit flag and bit 0 of the captured exit value.
REQ-013 SHALL have ports rst_led_o and clk_led_o, output, 1 bit each: LED drive.

Function
REQ-014 pll_locked_i, btn_rst_i and both straps SHALL each pass through a 2-flop synchronizer before use.
REQ-015 Debouncer: the debounced button SHALL change only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-016 The FSM SHALL have states ASSERT, HOLD, STRAP and RUN.
REQ-017 ASSERT -> HOLD when the synchronized lock is 1 and the debounced button is 0.
REQ-018 HOLD SHALL count 0..HOLD_CYCLES-1 and go to STRAP on the edge where the count equals HOLD_CYCLES-1.
REQ-019 STRAP SHALL last exactly 1 cycle, latch the synchronized straps into boot_select_o and execute_from_flash_o, then go to RUN.
REQ-020 From any state, lock=0 or debounced button=1 SHALL force ASSERT on the next edge and clear the hold counter; this takes priority over every other transition.
REQ-021 rst_no SHALL be a dedicated flop: set on the STRAP->RUN edge, cleared on any edge entering ASSERT; it is never decoded combinationally from the state.
REQ-022 Latency: rst_no SHALL rise HOLD_CYCLES+1 cycles after entering HOLD.
REQ-023 Straps SHALL hold their latched values in all states and update only in STRAP.
REQ-024 exit_valid_o SHALL set on the first cycle exit_valid_i=1 while in RUN; exit_value_o captures exit_value_i[0] on that same edge.
REQ-025 Once exit_valid_o is set, later exit_valid_i pulses SHALL be ignored; both exit outputs clear on entry to ASSERT.
REQ-026 rst_led_o SHALL equal rst_no.
REQ-027 clk_led_o SHALL equal the MSB of a free-running counter that wraps from all-ones to 0 and is reset only by rst_i.

Reset
REQ-028 On rst_i=1 (asynchronous), the following SHALL reset: state=ASSERT, rst_no=0, all counters=0, all synchronizers=0, debounced button=0, straps=0, exit outputs=0, clk_led_o=0.
REQ-029 After rst_i deasserts, the sequence SHALL restart from ASSERT; reset asserted mid-HOLD or in RUN aborts immediately with no partial strap update.

Structure
REQ-030 Package kronos_fpga_pkg SHALL hold the FSM state enum and the default DEBOUNCE_CYCLES and HOLD_CYCLES constants.
REQ-031 The debouncer (synchronizer plus counter) SHALL be the sub-module fpga_debouncer, parameterized by DEBOUNCE_CYCLES.
REQ-032 The block SHALL sit between the board pins/clock wizard and kronos_x_heep_top in xilinx_kronos_x_heep_top.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8)
REQ-033 Lock rises at cycle 10, button held 0 -> HOLD entered at cycle 12; rst_no=1 exactly 9 cycles later.
REQ-034 Button bounces 1,0,1,0 (1-cycle pulses) in RUN -> rst_no stays 1; button held 1 for 6 cycles -> rst_no=0 at debounce +1 cycle.
REQ-035 Lock drops at HOLD count 5 -> ASSERT next edge; on re-lock the full 8-cycle hold repeats.
REQ-036 boot_select_i=1 through STRAP, then toggled in RUN -> boot_select_o=1 and unchanged.
REQ-037 exit_valid_i pulses with value 0x1, then with 0x0 -> exit_valid_o=1, exit_value_o=1; button press clears both.
REQ-038 rst_i pulsed in RUN -> all outputs return to reset values asynchronously, then the sequence restarts.
